sprite_line_renderer: RTL
=========================

// Module: sprite_line_renderer
// PURPOSE
//   Per-scanline sprite compositor, downstream of the VGA timing driver on the 25 MHz VGAclock.
//   Consumes the driver's xPos/yPos counters and holds an 8-entry sprite table written by game logic.
//   During each line's blanking it selects up to MAX_PER_LINE sprites; during active video it emits one 8-bit colour per pixel.
// PARAMETERS
//   NUM_SPRITES   8      sprite table entries; index 0 = highest priority
//   MAX_PER_LINE  4      sprite slots latched per line
//   SPRITE_SIZE   16     square sprite edge, pixels
//   BG_COLOR      8'h00  colour where no sprite hits
// PORTS
//   VGAclock     in   1   pixel clock (25 MHz), the single clock
//   resetN       in   1   asynchronous, active-low reset
//   xPos         in   11  horizontal counter, 0..800; active columns are xPos 161..800
//   yPos         in   11  vertical counter, 0..524; active rows are yPos 0..479
//   spriteWe     in   1   table write strobe, 1 cycle
//   spriteIdx    in   3   table entry written
//   spriteX      in   10  left column, 0..639
//   spriteY      in   10  top row, 0..479
//   spriteColor  in   8   solid fill colour
//   spriteEn     in   1   entry enable
//   rgb          out  8   pixel colour, registered
//   pixelValid   out  1   rgb belongs to an active pixel
//   scanBusy     out  1   high while in SCAN
//   lineOverflow out  1   sticky: a line had > MAX_PER_LINE hits
// BEHAVIOUR
//   Reset (async, resetN=0): all table entries disabled with fields 0; slots cleared.
//     Also on reset: state=IDLE, rgb=0, pixelValid=0, scanBusy=0, lineOverflow=0.
//   Table write: on a VGAclock edge with spriteWe=1, entry[spriteIdx] <= {spriteX,spriteY,spriteColor,spriteEn}.
//     A write is visible to the next evaluation of that entry.
//     Writing an entry already scanned this line affects the next line only.
//   FSM states: IDLE, SCAN, DISPLAY.
//     IDLE -> SCAN: when xPos==0 && yPos<480. Clear slots, idx=0, count=0.
//     SCAN: evaluate entry[idx], one per cycle; idx==NUM_SPRITES-1 -> DISPLAY.
//       The 8-cycle scan completes well before xPos 161.
//     DISPLAY -> SCAN: on xPos==0 && yPos<480. DISPLAY -> IDLE: on xPos==0 && yPos>=480.
//     xPos==0 arriving while in SCAN restarts the scan. This cannot happen with legal timing, but must be safe.
//   Vertical hit: en && yPos>=Y && yPos<Y+SPRITE_SIZE, compared at 11 bits so there is no wrap.
//     On a hit with count<MAX_PER_LINE: slot[count] <= {X,color}, count++.
//     On a hit with count==MAX_PER_LINE: sprite dropped, lineOverflow <= 1. Cleared only by reset.
//   Pixel path: px = xPos-161 (11 bit).
//     Active when state==DISPLAY && yPos<480 && 161<=xPos<=800.
//     Horizontal hit for slot k: px>=slotX[k] && px<slotX[k]+SPRITE_SIZE, compared at 11 bits.
//       Sprites straddling column 639 clip; they do not wrap.
//     Colour is the lowest-numbered hit slot (table order = priority), else BG_COLOR.
//   Latency: rgb/pixelValid are registered, 1 VGAclock after the xPos/yPos they describe.
//     Inactive pixels: rgb=0, pixelValid=0.
//   Table and slots are independent: slots are frozen for the whole active span of the line.
// TESTING
//   1. Reset mid-line while DISPLAY with sprites active -> rgb=0, pixelValid=0, state IDLE, all entries disabled next frame.
//   2. Sprite0 X=100,Y=50,color=8'hE0: line 50 xPos 261..276 -> rgb=E0 one cycle later.
//      Same line, xPos 260 and 277 -> BG; line 49 and line 66 -> no hit anywhere.
//   3. Sprite1 X=100,Y=50,color=1C and Sprite3 same X/Y,color=03 -> overlap shows 1C.
//      Disable sprite1 -> 03 from the next line.
//   4. Five enabled sprites on row 200 -> sprites 0..3 drawn, sprite 4 absent, lineOverflow=1 and stays 1 after the frame.
//   5. Sprite X=630 -> columns 630..639 coloured, nothing on the next line's columns 0..5.
//      Sprite Y=470 -> rows 470..479 only.
//   6. Write entry 0 during line 50's DISPLAY -> line 50 pixels unchanged, line 51 reflects the new values.
//      Also: scanBusy is high exactly 8 cycles from xPos==0 on each active line.

Source files
------------

// File: rtl/sprite_line_renderer.sv
// sprite_line_renderer
//   Per-scanline sprite compositor on the VGA pixel clock. Game logic writes an
//   NUM_SPRITES-entry sprite table. While a line is blanking, the table is scanned
//   (one entry per cycle) and up to MAX_PER_LINE vertically-hit sprites are latched
//   into slots. During active video each pixel takes the colour of the
//   lowest-numbered slot that covers it horizontally. If no slot covers it, the
//   pixel takes BG_COLOR.
// Ports
//   VGAclock, resetN        pixel clock, async active-low reset
//   xPos, yPos              timing counters (active: x 161..800, y 0..479)
//   spriteWe/Idx/X/Y/Color/En  table write port
//   rgb, pixelValid         registered pixel colour, one clock after xPos/yPos
//   scanBusy                high while the per-line scan runs
//   lineOverflow            sticky: a line had more hits than slots
module sprite_line_renderer #(
    parameter int         NUM_SPRITES  = 8,
    parameter int         MAX_PER_LINE = 4,
    parameter int         SPRITE_SIZE  = 16,
    parameter logic [7:0] BG_COLOR     = 8'h00
) (
    input  logic                           VGAclock,
    input  logic                           resetN,
    input  logic [10:0]                    xPos,
    input  logic [10:0]                    yPos,
    input  logic                           spriteWe,
    input  logic [$clog2(NUM_SPRITES)-1:0] spriteIdx,
    input  logic [9:0]                     spriteX,
    input  logic [9:0]                     spriteY,
    input  logic [7:0]                     spriteColor,
    input  logic                           spriteEn,
    output logic [7:0]                     rgb,
    output logic                           pixelValid,
    output logic                           scanBusy,
    output logic                           lineOverflow
);
    localparam int          IDX_W = $clog2(NUM_SPRITES);
    localparam int          CNT_W = $clog2(MAX_PER_LINE + 1);
    localparam logic [10:0] SZ    = 11'(SPRITE_SIZE);
    localparam logic [10:0] ROWS  = 11'd480;
    localparam logic [10:0] X0    = 11'd161;
    localparam logic [10:0] X1    = 11'd800;

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        logic [7:0] color;
        logic       en;
    } entry_t;

    typedef struct packed {
        logic       vld;
        logic [9:0] x;
        logic [7:0] color;
    } slot_t;

    typedef enum logic [1:0] {IDLE, SCAN, DISPLAY} state_t;

    entry_t                          tbl [NUM_SPRITES];
    slot_t  [MAX_PER_LINE-1:0]       slots_q, slots_d;
    state_t                          state_q, state_d;
    logic   [IDX_W-1:0]              idx_q, idx_d;
    logic   [CNT_W-1:0]              cnt_q, cnt_d;
    logic                            ovf_q, ovf_d;

    // ---------------- sprite table ----------------
    always_ff @(posedge VGAclock or negedge resetN) begin
        if (!resetN) begin
            for (int i = 0; i < NUM_SPRITES; i++) tbl[i] <= '0;
        end else if (spriteWe) begin
            tbl[spriteIdx] <= '{x: spriteX, y: spriteY, color: spriteColor, en: spriteEn};
        end
    end

    // ---------------- scan FSM ----------------
    entry_t cur;
    logic   vhit;
    logic   line_edge, line_start;

    assign cur        = tbl[idx_q];
    // 11-bit compare so a sprite near the bottom never wraps to row 0
    assign vhit       = cur.en && (yPos >= {1'b0, cur.y}) && (yPos < ({1'b0, cur.y} + SZ));
    assign line_edge  = (xPos == 11'd0);
    assign line_start = line_edge && (yPos < ROWS);

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        slots_d = slots_q;
        ovf_d   = ovf_q;
        if (line_edge) begin
            // Start of every line, from any state. A line start that arrives
            // mid-scan restarts the scan cleanly.
            idx_d   = '0;
            cnt_d   = '0;
            slots_d = '0;
            state_d = line_start ? SCAN : IDLE;
        end else begin
            case (state_q)
                SCAN: begin
                    if (vhit) begin
                        if (cnt_q < CNT_W'(MAX_PER_LINE)) begin
                            for (int k = 0; k < MAX_PER_LINE; k++) begin
                                if (cnt_q == CNT_W'(k)) begin
                                    slots_d[k].vld   = 1'b1;
                                    slots_d[k].x     = cur.x;
                                    slots_d[k].color = cur.color;
                                end
                            end
                            cnt_d = cnt_q + 1'b1;
                        end else begin
                            ovf_d = 1'b1;
                        end
                    end
                    if (idx_q == IDX_W'(NUM_SPRITES - 1)) state_d = DISPLAY;
                    else                                   idx_d   = idx_q + 1'b1;
                end
                IDLE, DISPLAY: ;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge VGAclock or negedge resetN) begin
        if (!resetN) begin
            state_q <= IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
            slots_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            slots_q <= slots_d;
            ovf_q   <= ovf_d;
        end
    end

    assign scanBusy     = (state_q == SCAN);
    assign lineOverflow = ovf_q;

    // ---------------- pixel path ----------------
    logic [10:0]             px;
    logic                    active;
    logic [MAX_PER_LINE-1:0] hhit;
    logic [7:0]              pix_color;

    assign px     = xPos - X0;
    assign active = (state_q == DISPLAY) && (yPos < ROWS) && (xPos >= X0) && (xPos <= X1);

    // px never exceeds 639 while active, so sprites past the right edge clip
    generate
        for (genvar k = 0; k < MAX_PER_LINE; k++) begin : g_hit
            assign hhit[k] = slots_q[k].vld && (px >= {1'b0, slots_q[k].x})
                           && (px < ({1'b0, slots_q[k].x} + SZ));
        end
    endgenerate

    // Slots fill in table order, so the lowest hit slot is the highest priority
    always_comb begin
        pix_color = BG_COLOR;
        for (int k = MAX_PER_LINE - 1; k >= 0; k--) begin
            if (hhit[k]) pix_color = slots_q[k].color;
        end
    end

    always_ff @(posedge VGAclock or negedge resetN) begin
        if (!resetN) begin
            rgb        <= 8'h00;
            pixelValid <= 1'b0;
        end else begin
            rgb        <= active ? pix_color : 8'h00;
            pixelValid <= active;
        end
    end

endmodule
